// File: rtl/requant_pack_engine_if.sv
// requant_pack_engine_if: sample input stream, packed-word output stream and requant config.
interface requant_pack_engine_if #(
    parameter int IN_WIDTH    = 18,
    parameter int OUT_WIDTH   = 8,
    parameter int SCALE_WIDTH = 16,
    parameter int SHIFT_WIDTH = 5,
    parameter int PACK_N      = 4
);
    logic [IN_WIDTH-1:0]         din;
    logic                        din_valid;
    logic                        din_ready;
    logic [PACK_N*OUT_WIDTH-1:0] dout;
    logic [PACK_N-1:0]           dout_keep;
    logic                        dout_valid;
    logic                        dout_ready;
    logic [SCALE_WIDTH-1:0]      scale_config;
    logic [SHIFT_WIDTH-1:0]      shift_config;
    logic                        config_en;
    logic                        flush;

    modport slave (
        input  din, din_valid, dout_ready, scale_config, shift_config, config_en, flush,
        output din_ready, dout, dout_keep, dout_valid
    );
    modport master (
        output din, din_valid, dout_ready, scale_config, shift_config, config_en, flush,
        input  din_ready, dout, dout_keep, dout_valid
    );
endinterface

// File: rtl/requant_pack_engine.sv
// requant_pack_engine: scale, shift and ReLU-clamp signed accumulations to unsigned bytes, packed PACK_N per word.
// Define REQUANT_ROUND_EN for round-half-up shifting; otherwise the shift truncates toward minus infinity.
module requant_pack_engine #(
    parameter int IN_WIDTH    = 18,
    parameter int OUT_WIDTH   = 8,
    parameter int SCALE_WIDTH = 16,
    parameter int SHIFT_WIDTH = 5,
    parameter int PACK_N      = 4
) (
    input logic clk,
    input logic rst_n,
    requant_pack_engine_if.slave bus
);
    localparam int P  = IN_WIDTH + SCALE_WIDTH + 1;
    localparam int LW = $clog2(PACK_N);
    localparam logic [LW-1:0] LAST = LW'(PACK_N - 1);

    logic [SCALE_WIDTH-1:0]      scale_q, scale_d;
    logic [SHIFT_WIDTH-1:0]      shift_q, shift_d, sh1_q, sh1_d;
    logic [P-1:0]                prod_q, prod_d, din_x, scale_x;
    logic [P:0]                  rnd;
    logic signed [P:0]           sum, t;
    logic [OUT_WIDTH-1:0]        byte_q, byte_d, clamp;
    logic                        v1_q, v1_d, v2_q, v2_d;
    logic [PACK_N*OUT_WIDTH-1:0] acc_q, acc_d, acc_w, dout_q, dout_d;
    logic [PACK_N-1:0]           keep_q, keep_d, keep_part;
    logic [LW-1:0]               lane_q, lane_d;
    logic                        dv_q, dv_d, fp_q, fp_d;
    logic                        full, stall, pipe_en, accept, load, fl_done;

    // The shift amount travels with its sample so a config change only affects later samples.
`ifdef REQUANT_ROUND_EN
    assign rnd = (sh1_q == '0) ? '0 : ((P+1)'(1) << (sh1_q - 1'b1));
`else
    assign rnd = '0;
`endif

    assign full          = lane_q == LAST;
    assign stall         = v2_q && full && dv_q && !bus.dout_ready;
    assign pipe_en       = !stall;
    assign bus.din_ready = pipe_en && !fp_q;
    assign accept        = bus.din_valid && bus.din_ready;
    assign load          = pipe_en && v2_q && full;
    assign fl_done       = fp_q && !v1_q && !v2_q && (!dv_q || bus.dout_ready);
    assign din_x         = {{(P-IN_WIDTH){bus.din[IN_WIDTH-1]}}, bus.din};
    assign scale_x       = {{(P-SCALE_WIDTH){1'b0}}, scale_q};
    assign sum           = {prod_q[P-1], prod_q} + rnd;
    assign t             = sum >>> sh1_q;
    assign clamp         = t[P] ? '0 : (|t[P-1:OUT_WIDTH]) ? '1 : t[OUT_WIDTH-1:0];
    assign bus.dout      = dout_q;
    assign bus.dout_keep = keep_q;
    assign bus.dout_valid = dv_q;

    always_comb begin
        acc_w = acc_q;
        acc_w[lane_q*OUT_WIDTH +: OUT_WIDTH] = byte_q;
        for (int k = 0; k < PACK_N; k++) keep_part[k] = k < int'(lane_q);
    end

    always_comb begin
        scale_d = bus.config_en ? bus.scale_config : scale_q;
        shift_d = bus.config_en ? bus.shift_config : shift_q;
        prod_d  = pipe_en ? din_x * scale_x : prod_q;
        sh1_d   = pipe_en ? shift_q : sh1_q;
        v1_d    = pipe_en ? accept : v1_q;
        byte_d  = pipe_en ? clamp : byte_q;
        v2_d    = pipe_en ? v1_q : v2_q;
        acc_d   = acc_q;
        lane_d  = lane_q;
        dout_d  = dout_q;
        keep_d  = keep_q;
        dv_d    = dv_q && !bus.dout_ready;
        fp_d    = fp_q || bus.flush;
        if (pipe_en && v2_q) begin
            acc_d  = full ? '0 : acc_w;
            lane_d = full ? '0 : lane_q + 1'b1;
        end
        if (load) begin
            dout_d = acc_w;
            keep_d = '1;
            dv_d   = 1'b1;
        end
        // Pipeline is empty here, so the partial word never collides with a packer load.
        if (fl_done) begin
            fp_d = 1'b0;
            if (lane_q != '0) begin
                dout_d = acc_q;
                keep_d = keep_part;
                dv_d   = 1'b1;
                lane_d = '0;
                acc_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scale_q <= '0;
            shift_q <= '0;
            sh1_q   <= '0;
            prod_q  <= '0;
            v1_q    <= 1'b0;
            byte_q  <= '0;
            v2_q    <= 1'b0;
            acc_q   <= '0;
            lane_q  <= '0;
            dout_q  <= '0;
            keep_q  <= '0;
            dv_q    <= 1'b0;
            fp_q    <= 1'b0;
        end else begin
            scale_q <= scale_d;
            shift_q <= shift_d;
            sh1_q   <= sh1_d;
            prod_q  <= prod_d;
            v1_q    <= v1_d;
            byte_q  <= byte_d;
            v2_q    <= v2_d;
            acc_q   <= acc_d;
            lane_q  <= lane_d;
            dout_q  <= dout_d;
            keep_q  <= keep_d;
            dv_q    <= dv_d;
            fp_q    <= fp_d;
        end
    end
endmodule

// File: tb/tb_requant_pack_engine.sv
// tb_requant_pack_engine: directed vectors; expected words queued at issue, checked by a monitor on each handshake.
module tb_requant_pack_engine;
    localparam int IW = 18, OW = 8, SW = 16, HW = 5, PN = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [PN+PN*OW-1:0] exp_q [$];
    logic [PN+PN*OW-1:0] mon_e;
    int n_vec = 0;
    int n_fail = 0;

    requant_pack_engine_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SCALE_WIDTH(SW), .SHIFT_WIDTH(HW), .PACK_N(PN)) bus ();
    requant_pack_engine #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SCALE_WIDTH(SW), .SHIFT_WIDTH(HW), .PACK_N(PN)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.dout_valid && bus.dout_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h keep %0h, none expected", bus.dout, bus.dout_keep);
            end else begin
                mon_e = exp_q.pop_front();
                chk("word", bus.dout, mon_e[PN*OW-1:0]);
                chk("keep", bus.dout_keep, mon_e[PN+PN*OW-1:PN*OW]);
            end
        end
    end

    task automatic expect_word(input logic [PN*OW-1:0] w, input logic [PN-1:0] k);
        exp_q.push_back({k, w});
    endtask

    task automatic send(input int v);
        int t = 0;
        bus.din = IW'(v);
        bus.din_valid = 1'b1;
        @(negedge clk);
        while (!bus.din_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.din_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: din_ready 0 expected 1");
        end
        @(posedge clk);
        #1 bus.din_valid = 1'b0;
    endtask

    task automatic cfg(input int s, input int h);
        bus.scale_config = SW'(s);
        bus.shift_config = HW'(h);
        bus.config_en = 1'b1;
        @(posedge clk);
        #1 bus.config_en = 1'b0;
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.din = '0;
        bus.din_valid = 1'b0;
        bus.dout_ready = 1'b1;
        bus.scale_config = '0;
        bus.shift_config = '0;
        bus.config_en = 1'b0;
        bus.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.dout_valid, 0);
        chk("rst_keep", bus.dout_keep, 0);
        chk("rst_dout", bus.dout, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Clamp both ways plus the three-cycle latency
        cfg(256, 8);
        expect_word(32'hFF000A05, 4'hF);
        send(5); send(10); send(-3); send(300);
        chk("lat_e0", bus.dout_valid, 0);
        @(posedge clk); #1;
        chk("lat_e1", bus.dout_valid, 0);
        @(posedge clk); #1;
        chk("lat_e2", bus.dout_valid, 1);
        drain();

        cfg(1, 1);
`ifdef REQUANT_ROUND_EN
        expect_word(32'h01000302, 4'hF);
`else
        expect_word(32'h00000201, 4'hF);
`endif
        send(3); send(5); send(-1); send(1);
        drain();

        // Backpressure: output held stable, then three words in order
        cfg(1, 0);
        bus.dout_ready = 1'b0;
        expect_word(32'h04030201, 4'hF);
        expect_word(32'h08070605, 4'hF);
        expect_word(32'h0C0B0A09, 4'hF);
        fork
            for (int i = 1; i <= 12; i++) send(i);
            begin
                repeat (20) @(posedge clk);
                #1;
                chk("stall_din_ready", bus.din_ready, 0);
                chk("stall_valid", bus.dout_valid, 1);
                chk("stall_word_a", bus.dout, 32'h04030201);
                repeat (3) @(posedge clk);
                #1;
                chk("stall_word_b", bus.dout, 32'h04030201);
                bus.dout_ready = 1'b1;
            end
        join
        drain();

        // Partial flush, then a flush with nothing accumulated
        expect_word(32'h00000201, 4'b0011);
        send(1); send(2);
        pulse_flush();
        chk("flush_blocks", bus.din_ready, 0);
        drain();
        chk("flush_released", bus.din_ready, 1);
        pulse_flush();
        repeat (4) @(posedge clk);
        #1;
        chk("empty_flush_valid", bus.dout_valid, 0);
        chk("empty_flush_ready", bus.din_ready, 1);

        // Asynchronous reset mid-word discards lanes and config
        send(1); send(2); send(3);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.dout_valid, 0);
        chk("arst_keep", bus.dout_keep, 0);
        chk("arst_dout", bus.dout, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cfg(1, 0);
        expect_word(32'h06070809, 4'hF);
        send(9); send(8); send(7); send(6);
        drain();

        // Scale change between samples two and three
        expect_word(32'h14140A0A, 4'hF);
        send(10); send(10);
        cfg(2, 0);
        send(10); send(10);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
